// File: rtl/seg7_scan_ctrl_if.sv
// Bundles the digit write port, scan controls and the display pins for seg7_scan_ctrl.
// The master drives writes and controls; the slave (the controller) drives the pins.
interface seg7_scan_ctrl_if;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic       wr_dp;
   logic [7:0] digit_en;
   logic       blank;
   logic [6:0] seg;
   logic       dp;
   logic [7:0] an;
   logic       frame_done;

   modport master (
      output wr_en, wr_addr, wr_data, wr_dp, digit_en, blank,
      input  seg, dp, an, frame_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_dp, digit_en, blank,
      output seg, dp, an, frame_done
   );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display,
// with per-digit hex/dp storage and an all-dark gap between digits against ghosting.
module seg7_scan_ctrl #(
   parameter int TICKS_PER_DIGIT = 100000,
   parameter int GAP_TICKS       = 2,
   parameter int CNT_W           = 17
) (
   input  logic            clk,
   input  logic            rst,
   seg7_scan_ctrl_if.slave bus
);

   typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_t;

   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
   // With the gap disabled the GAP state is never entered, so its terminal value is moot.
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0][3:0]  val_q, val_d;
   logic [7:0]       dpb_q, dpb_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             fd_q, fd_d;
   logic             adv;
   logic             lit;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      adv     = 1'b0;
      unique case (state_q)
         SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               if (GAP_TICKS > 0) state_d = GAP;
               else               adv     = 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = SHOW;
               adv     = 1'b1;
            end
         end
      endcase
      if (adv) idx_d = idx_q + 3'd1;
      fd_d = adv && (idx_q == 3'd7);
   end

   always_comb begin
      val_d = val_q;
      dpb_d = dpb_q;
      if (bus.wr_en) begin
         val_d[bus.wr_addr] = bus.wr_data;
         dpb_d[bus.wr_addr] = bus.wr_dp;
      end
   end

   // A disabled or blanked digit still occupies its slot; only the pins go dark.
   always_comb begin
      lit   = (state_q == SHOW) && bus.digit_en[idx_q] && !bus.blank;
      an_d  = lit ? ~(8'b1 << idx_q) : 8'hFF;
      seg_d = lit ? hex_to_seg(val_q[idx_q]) : 7'h7F;
      dp_d  = lit ? ~dpb_q[idx_q] : 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SHOW;
         idx_q   <= '0;
         cnt_q   <= '0;
         val_q   <= '0;
         dpb_q   <= '0;
         an_q    <= 8'hFF;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         dpb_q   <= dpb_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         fd_q    <= fd_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a scan-position model predicts every output cycle for a
// gapped instance (4 ticks + 1 gap) and a gapless instance (4 ticks, no gap).
module tb_seg7_scan_ctrl;

   logic clk;
   logic rst;

   seg7_scan_ctrl_if bus0 ();
   seg7_scan_ctrl_if bus1 ();

   seg7_scan_ctrl #(.TICKS_PER_DIGIT(4), .GAP_TICKS(1), .CNT_W(3)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   seg7_scan_ctrl #(.TICKS_PER_DIGIT(4), .GAP_TICKS(0), .CNT_W(3)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      logic [7:0] an1;
      logic [6:0] seg1;
      logic       fd1;
   } exp_t;

   exp_t exp_q[$];

   int tests = 0;
   int fails = 0;
   int s     = 0;
   logic [3:0] mval [8];
   logic       mdp  [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s at edge %0d: got %h expected %h", tag, s, obs, expv);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         mval[i] = 4'h0;
         mdp[i]  = 1'b0;
      end
   endtask

   // Predict the outputs after the coming edge, then advance one clock and compare.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         exp_t e;
         int sn, q, d, w;
         logic lit;
         sn    = s + 1;
         q     = (sn - 1) % 40;
         d     = q / 5;
         w     = q % 5;
         lit   = (w < 4) && bus0.digit_en[d] && !bus0.blank;
         e.an  = lit ? ~(8'b1 << d) : 8'hFF;
         e.seg = lit ? dec(mval[d]) : 7'h7F;
         e.dp  = lit ? ~mdp[d] : 1'b1;
         e.fd  = (sn % 40) == 0;
         q      = (sn - 1) % 32;
         d      = q / 4;
         e.an1  = ~(8'b1 << d);
         e.seg1 = 7'h40;
         e.fd1  = (sn % 32) == 0;
         if (bus0.wr_en) begin
            mval[bus0.wr_addr] = bus0.wr_data;
            mdp[bus0.wr_addr]  = bus0.wr_dp;
         end
         exp_q.push_back(e);
         @(posedge clk);
         #1;
         s++;
         e = exp_q.pop_front();
         chk("an",    bus0.an,                e.an);
         chk("seg",   {1'b0, bus0.seg},       {1'b0, e.seg});
         chk("dp",    {7'b0, bus0.dp},        {7'b0, e.dp});
         chk("frame", {7'b0, bus0.frame_done}, {7'b0, e.fd});
         chk("an_nogap",    bus1.an,                 e.an1);
         chk("seg_nogap",   {1'b0, bus1.seg},        {1'b0, e.seg1});
         chk("frame_nogap", {7'b0, bus1.frame_done}, {7'b0, e.fd1});
      end
   endtask

   task automatic write_digit(input logic [2:0] a, input logic [3:0] v, input logic p);
      bus0.wr_en   = 1'b1;
      bus0.wr_addr = a;
      bus0.wr_data = v;
      bus0.wr_dp   = p;
      step(1);
      bus0.wr_en   = 1'b0;
   endtask

   task automatic check_dark(input string tag);
      chk({tag, "_an"},  bus0.an, 8'hFF);
      chk({tag, "_seg"}, {1'b0, bus0.seg}, 8'h7F);
      chk({tag, "_dp"},  {7'b0, bus0.dp}, 8'h01);
      chk({tag, "_fd"},  {7'b0, bus0.frame_done}, 8'h00);
      chk({tag, "_an_nogap"}, bus1.an, 8'hFF);
   endtask

   initial begin
      rst           = 1'b1;
      bus0.wr_en    = 1'b0;
      bus0.wr_addr  = 3'd0;
      bus0.wr_data  = 4'h0;
      bus0.wr_dp    = 1'b0;
      bus0.digit_en = 8'hFF;
      bus0.blank    = 1'b0;
      bus1.wr_en    = 1'b0;
      bus1.wr_addr  = 3'd0;
      bus1.wr_data  = 4'h0;
      bus1.wr_dp    = 1'b0;
      bus1.digit_en = 8'hFF;
      bus1.blank    = 1'b0;
      model_clear();

      @(posedge clk);
      @(posedge clk);
      #1;
      check_dark("reset");
      rst = 1'b0;
      s   = 0;

      step(30);

      for (int i = 0; i < 8; i++)
         write_digit(3'(i), 4'(i + 1), i == 3);
      step(80);

      bus0.digit_en = 8'h0F;
      step(80);

      for (int k = 0; k < 50 && bus0.an !== 8'hFB; k++) step(1);
      tests++;
      assert (bus0.an === 8'hFB) else begin
         fails++;
         $error("FAIL wait_digit2: an %h expected %h", bus0.an, 8'hFB);
      end
      write_digit(3'd2, 4'hA, 1'b0);
      step(20);

      bus0.blank = 1'b1;
      step(12);
      bus0.blank = 1'b0;
      step(40);

      bus0.digit_en = 8'hFF;
      step(3);
      #3;
      rst = 1'b1;
      #1;
      check_dark("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      s   = 0;
      model_clear();
      step(45);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
